sd_init_sequencer: RTL and testbench

//  Command-level controller for SD SPI-mode power-up: runs the dummy-clock preamble, then CMD0, CMD8,
//  the CMD55/ACMD41 poll loop and CMD58, classifying the card (v1/v2, SC/HC).

---
 rtl/sd_pkg.sv | 46 ++++
 rtl/sd_init_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode power-up sequencer: FSM states,
// command indices, CRC7 constants, R1 bit positions and error codes.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_DUMMY, ST_C0, ST_W0, ST_C8, ST_W8, ST_C55, ST_W55,
    ST_A41, ST_W41, ST_C58, ST_W58, ST_DONE, ST_ERR
  } state_t;

  localparam logic [5:0] CMD0_IDX   = 6'd0;
  localparam logic [5:0] CMD8_IDX   = 6'd8;
  localparam logic [5:0] CMD55_IDX  = 6'd55;
  localparam logic [5:0] ACMD41_IDX = 6'd41;
  localparam logic [5:0] CMD58_IDX  = 6'd58;

  localparam logic [6:0] CRC_CMD0   = 7'h4A;
  localparam logic [6:0] CRC_CMD8   = 7'h43;
  localparam logic [6:0] CRC_CMD55  = 7'h32;
  localparam logic [6:0] CRC_A41_V2 = 7'h3B;
  localparam logic [6:0] CRC_A41_V1 = 7'h72;
  localparam logic [6:0] CRC_CMD58  = 7'h7E;

  // CMD8: 2.7-3.6 V supply plus the 0xAA check pattern echoed back in R7
  localparam logic [31:0] ARG_CMD8    = 32'h0000_01AA;
  localparam logic [11:0] R7_ECHO     = 12'h1AA;
  localparam logic [31:0] ARG_A41_HCS = 32'h4000_0000;

  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ILLEGAL_BIT = 2;
  localparam logic [7:0] R1_READY = 8'h00;
  localparam logic [7:0] R1_IDLE  = 8'h01;

  localparam int OCR_PWRUP_BIT = 31;
  localparam int OCR_CCS_BIT   = 30;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CMD0   = 3'd1;
  localparam logic [2:0] ERR_CMD8   = 3'd2;
  localparam logic [2:0] ERR_ACMD41 = 3'd3;
  localparam logic [2:0] ERR_CMD58  = 3'd4;

  function automatic logic is_cmd_state(input state_t s);
    return s inside {ST_C0, ST_C8, ST_C55, ST_A41, ST_C58};
  endfunction

endpackage

// File: rtl/sd_init_sequencer.sv
// SD SPI-mode power-up controller: dummy-clock preamble, CMD0, CMD8,
// CMD55/ACMD41 polling and CMD58, classifying the card as v1/v2 and SC/HC.
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int DUMMY_CYCLES   = 80,
  parameter int CMD_RETRIES    = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic        input_clk,
  input  logic        resend,
  input  logic        start,
  output logic        dummy_en,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic [6:0]  cmd_crc,
  input  logic        rsp_valid,
  input  logic        rsp_timeout,
  input  logic [7:0]  rsp_r1,
  input  logic [31:0] rsp_ext,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic        card_v2,
  output logic        card_hc
);

  localparam int DW   = $clog2(DUMMY_CYCLES + 1);
  localparam int C0W  = $clog2(CMD_RETRIES + 1);
  localparam int A41W = $clog2(ACMD41_RETRIES + 1);
  localparam logic [DW-1:0]   DUMMY_LAST = DW'(DUMMY_CYCLES - 1);
  localparam logic [C0W-1:0]  C0_MAX     = C0W'(CMD_RETRIES);
  localparam logic [A41W-1:0] A41_MAX    = A41W'(ACMD41_RETRIES);

  state_t            state_q, state_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [C0W-1:0]    cnt0_q, cnt0_d;
  logic [A41W-1:0]   a41_q, a41_d;
  logic              v2_d, hc_d;
  logic [2:0]        err_d;
  logic [5:0]        idx_d;
  logic [31:0]       arg_d;
  logic [6:0]        crc_d;
  logic              xfer, rsp_any, r1_ok;
  logic              unused_ext;

  assign xfer       = cmd_valid & cmd_ready;
  assign rsp_any    = rsp_valid | rsp_timeout;
  assign r1_ok      = rsp_r1 == R1_READY;
  assign unused_ext = ^rsp_ext[29:12];

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    cnt0_d  = cnt0_q;
    a41_d   = a41_q;
    v2_d    = card_v2;
    hc_d    = card_hc;
    err_d   = err_code;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_DUMMY;
          dcnt_d  = '0;
          cnt0_d  = '0;
          a41_d   = '0;
          v2_d    = 1'b0;
          hc_d    = 1'b0;
          err_d   = ERR_NONE;
        end
      end
      ST_DUMMY: begin
        if (dcnt_q == DUMMY_LAST) begin
          state_d = ST_C0;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ST_C0:  if (xfer) state_d = ST_W0;
      ST_C8:  if (xfer) state_d = ST_W8;
      ST_C55: if (xfer) state_d = ST_W55;
      ST_A41: if (xfer) state_d = ST_W41;
      ST_C58: if (xfer) state_d = ST_W58;
      // A failed CMD0 retries without a new preamble
      ST_W0: begin
        if (rsp_valid && rsp_r1 == R1_IDLE) begin
          state_d = ST_C8;
        end else if (rsp_any) begin
          cnt0_d = (cnt0_q == C0_MAX) ? cnt0_q : cnt0_q + C0W'(1);
          if (cnt0_d == C0_MAX) begin
            state_d = ST_ERR;
            err_d   = ERR_CMD0;
          end else begin
            state_d = ST_C0;
          end
        end
      end
      ST_W8: begin
        if (rsp_valid && rsp_r1[R1_ILLEGAL_BIT]) begin
          v2_d    = 1'b0;
          state_d = ST_C55;
        end else if (rsp_valid && rsp_r1 == R1_IDLE && rsp_ext[11:0] == R7_ECHO) begin
          v2_d    = 1'b1;
          state_d = ST_C55;
        end else if (rsp_any) begin
          state_d = ST_ERR;
          err_d   = ERR_CMD8;
        end
      end
      ST_W55: begin
        if (rsp_valid && (r1_ok || rsp_r1 == R1_IDLE)) begin
          state_d = ST_A41;
        end else if (rsp_any) begin
          state_d = ST_ERR;
          err_d   = ERR_ACMD41;
        end
      end
      ST_W41: begin
        if (rsp_valid && r1_ok) begin
          if (card_v2) begin
            state_d = ST_C58;
          end else begin
            hc_d    = 1'b0;
            state_d = ST_DONE;
          end
        end else if (rsp_valid && rsp_r1 == R1_IDLE) begin
          a41_d = (a41_q == A41_MAX) ? a41_q : a41_q + A41W'(1);
          if (a41_d == A41_MAX) begin
            state_d = ST_ERR;
            err_d   = ERR_ACMD41;
          end else begin
            state_d = ST_C55;
          end
        end else if (rsp_any) begin
          state_d = ST_ERR;
          err_d   = ERR_ACMD41;
        end
      end
      ST_W58: begin
        if (rsp_valid && r1_ok && rsp_ext[OCR_PWRUP_BIT]) begin
          hc_d    = rsp_ext[OCR_CCS_BIT];
          state_d = ST_DONE;
        end else if (rsp_any) begin
          state_d = ST_ERR;
          err_d   = ERR_CMD58;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command fields follow the state being entered so they register with cmd_valid
  always_comb begin
    idx_d = '0;
    arg_d = '0;
    crc_d = '0;
    case (state_d)
      ST_C0:  begin idx_d = CMD0_IDX;  crc_d = CRC_CMD0;  end
      ST_C8:  begin idx_d = CMD8_IDX;  arg_d = ARG_CMD8;  crc_d = CRC_CMD8; end
      ST_C55: begin idx_d = CMD55_IDX; crc_d = CRC_CMD55; end
      ST_A41: begin
        idx_d = ACMD41_IDX;
        arg_d = v2_d ? ARG_A41_HCS : 32'h0;
        crc_d = v2_d ? CRC_A41_V2 : CRC_A41_V1;
      end
      ST_C58: begin idx_d = CMD58_IDX; crc_d = CRC_CMD58; end
      default: ;
    endcase
  end

  always_ff @(posedge input_clk) begin
    if (!resend) begin
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      cnt0_q    <= '0;
      a41_q     <= '0;
      dummy_en  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
      cmd_crc   <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      err_code  <= ERR_NONE;
      card_v2   <= 1'b0;
      card_hc   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      cnt0_q    <= cnt0_d;
      a41_q     <= a41_d;
      dummy_en  <= state_d == ST_DUMMY;
      cmd_valid <= is_cmd_state(state_d);
      cmd_index <= idx_d;
      cmd_arg   <= arg_d;
      cmd_crc   <= crc_d;
      busy      <= !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
      init_done <= state_d == ST_DONE;
      init_err  <= state_d == ST_ERR;
      err_code  <= err_d;
      card_v2   <= v2_d;
      card_hc   <= hc_d;
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Randomised bench for sd_init_sequencer: card/engine model, scoreboard of
// expected commands and end-of-sequence classification.
module tb_sd_init_sequencer;

  localparam int NDUMMY = 80;
  localparam int NCMD0  = 8;
  localparam int NA41   = 4;

  typedef logic [44:0] cmd_t;  // {index, arg, crc}

  logic        input_clk, resend, start, cmd_ready, rsp_valid, rsp_timeout;
  logic [7:0]  rsp_r1;
  logic [31:0] rsp_ext;
  logic        dummy_en, cmd_valid, busy, init_done, init_err, card_v2, card_hc;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic [2:0]  err_code;

  sd_init_sequencer #(.DUMMY_CYCLES(NDUMMY), .CMD_RETRIES(NCMD0), .ACMD41_RETRIES(NA41)) dut (
    .input_clk(input_clk), .resend(resend), .start(start), .dummy_en(dummy_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_r1(rsp_r1),
    .rsp_ext(rsp_ext), .busy(busy), .init_done(init_done), .init_err(init_err),
    .err_code(err_code), .card_v2(card_v2), .card_hc(card_hc));

  initial begin
    input_clk = 1'b0;
    forever #5 input_clk = ~input_clk;
  end

  int n_checks = 0, n_pass = 0;
  int dummy_cnt = 0, n41_seen = 0;
  cmd_t exp_q[$];

  // Scenario knobs shared by the card model and the reference model
  int          s_cmd0_fail, s_cmd8, s_stmax, s_idle;
  bit          s_cmd55_bad, s_force_stall, s_hold41;
  logic [31:0] s_ext58;
  int          a0_cnt, a41_cnt, c55_cnt;

  bit          e_done, e_err, e_v2, e_hc;
  logic [2:0]  e_code;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, req);
  endtask

  function automatic logic [63:0] outs();
    return {9'b0, dummy_en, cmd_valid, cmd_index, cmd_arg, cmd_crc,
            busy, init_done, init_err, err_code, card_v2, card_hc};
  endfunction

  task automatic push(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc);
    exp_q.push_back({idx, arg, crc});
  endtask

  // Reference: the command list and outcome implied by the scenario knobs
  task automatic build_expected();
    bit v2;
    exp_q.delete();
    e_done = 0; e_err = 0; e_code = 0; e_v2 = 0; e_hc = 0;
    if (s_cmd0_fail >= NCMD0) begin
      repeat (NCMD0) push(6'd0, 32'h0, 7'h4A);
      e_err = 1; e_code = 3'd1;
      return;
    end
    repeat (s_cmd0_fail + 1) push(6'd0, 32'h0, 7'h4A);
    push(6'd8, 32'h1AA, 7'h43);
    if (s_cmd8 == 2) begin e_err = 1; e_code = 3'd2; return; end
    v2 = (s_cmd8 == 0);
    e_v2 = v2;
    for (int k = 0; ; k++) begin
      push(6'd55, 32'h0, 7'h32);
      if (s_cmd55_bad) begin e_err = 1; e_code = 3'd3; return; end
      push(6'd41, v2 ? 32'h4000_0000 : 32'h0, v2 ? 7'h3B : 7'h72);
      if (s_hold41) return;
      if (k >= s_idle) break;
      if (k + 1 == NA41) begin e_err = 1; e_code = 3'd3; return; end
    end
    if (!v2) begin e_done = 1; return; end
    push(6'd58, 32'h0, 7'h7E);
    if (s_ext58[31]) begin e_done = 1; e_hc = s_ext58[30]; end
    else begin e_err = 1; e_code = 3'd4; end
  endtask

  task automatic give(input logic [7:0] r1);
    rsp_valid = 1'b1;
    rsp_r1    = r1;
    if ($urandom_range(0, 3) == 0) rsp_timeout = 1'b1;
  endtask

  task automatic respond(input logic [5:0] idx);
    int r;
    logic [31:0] w;
    w = $urandom;
    r = $urandom_range(0, 2);
    rsp_ext = w;
    case (idx)
      6'd0: begin
        a0_cnt++;
        if (a0_cnt > s_cmd0_fail) give(8'h01);
        else if (r == 0) rsp_timeout = 1'b1;
        else give(r == 1 ? 8'h00 : 8'h05);
      end
      6'd8: begin
        if (s_cmd8 == 0) begin rsp_ext = {w[31:12], 12'h1AA}; give(8'h01); end
        else if (s_cmd8 == 1) give({7'h02, w[0]});
        else if (r == 0) rsp_timeout = 1'b1;
        else if (r == 1) begin rsp_ext = {w[31:12], 12'h1AB}; give(8'h01); end
        else begin rsp_ext = {w[31:12], 12'h1AA}; give(8'h00); end
      end
      6'd55: begin
        c55_cnt++;
        if (s_cmd55_bad && c55_cnt == 1) give(8'h05);
        else give({7'h0, w[1]});
      end
      6'd41: begin
        if (!s_hold41) begin
          a41_cnt++;
          give(a41_cnt <= s_idle ? 8'h01 : 8'h00);
        end
      end
      6'd58: begin rsp_ext = s_ext58; give(8'h00); end
      default: ;
    endcase
  endtask

  // Command engine / card: drives inputs just after each rising edge
  initial begin
    bit will_xfer;
    logic [5:0] xidx, pidx;
    int pend, stall;
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_timeout = 1'b0; rsp_r1 = '0; rsp_ext = '0;
    will_xfer = 0; xidx = '0; pidx = '0; pend = -1; stall = 0;
    forever begin
      @(posedge input_clk);
      #1;
      rsp_valid = 1'b0;
      rsp_timeout = 1'b0;
      if (!resend) begin
        will_xfer = 0;
        pend = -1;
      end else begin
        if (will_xfer) begin
          pend  = $urandom_range(0, 3);
          pidx  = xidx;
          stall = s_force_stall ? 5 : $urandom_range(0, s_stmax);
        end
        if (pend == 0) begin
          respond(pidx);
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end else if (dummy_en) begin
          a0_cnt = 0; a41_cnt = 0; c55_cnt = 0;
          stall = s_force_stall ? 5 : $urandom_range(0, s_stmax);
          if ($urandom_range(0, 7) == 0) begin
            rsp_valid = 1'b1; rsp_r1 = 8'h01; rsp_ext = 32'h1AA;
          end else if ($urandom_range(0, 7) == 0) begin
            rsp_timeout = 1'b1;
          end
        end
      end
      if (cmd_valid && stall > 0) begin
        cmd_ready = 1'b0;
        stall--;
      end else begin
        cmd_ready = 1'b1;
      end
      will_xfer = cmd_valid && cmd_ready;
      xidx = cmd_index;
    end
  end

  // Monitor: pops the scoreboard on every accepted command
  initial begin
    bit pv, pr, pd;
    cmd_t pf, e;
    pv = 0; pr = 0; pd = 0; pf = '0;
    forever begin
      @(negedge input_clk);
      if (dummy_en) begin
        if (!pd) dummy_cnt = 0;
        dummy_cnt++;
      end
      pd = dummy_en;
      if (resend && pv && !pr)
        check("cmd_held", {18'b0, cmd_valid, cmd_index, cmd_arg, cmd_crc}, {18'b0, 1'b1, pf});
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL cmd_unexpected: actual idx=%0d arg=%h required none", cmd_index, cmd_arg);
        end else begin
          e = exp_q.pop_front();
          check("cmd_fields", {19'b0, cmd_index, cmd_arg, cmd_crc}, {19'b0, e});
        end
        if (cmd_index == 6'd41) n41_seen++;
      end
      pv = cmd_valid;
      pr = cmd_ready;
      pf = {cmd_index, cmd_arg, cmd_crc};
    end
  end

  task automatic pulse_start();
    @(negedge input_clk);
    start = 1'b1;
    @(negedge input_clk);
    start = 1'b0;
    check("start_clears", {56'b0, dummy_en, cmd_valid, busy, init_done, init_err, err_code},
          {56'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0});
    check("start_clears_card", {62'b0, card_v2, card_hc}, 64'd0);
  endtask

  task automatic run(input string nm, input int c0f, input int c8, input bit c55b, input int idle,
                     input logic [31:0] e58, input int stmax, input bit fstall, input bit poke);
    bit got;
    int poke_at;
    s_cmd0_fail = c0f; s_cmd8 = c8; s_cmd55_bad = c55b; s_idle = idle; s_ext58 = e58;
    s_stmax = stmax; s_force_stall = fstall; s_hold41 = 0;
    build_expected();
    poke_at = $urandom_range(1, 150);
    pulse_start();
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge input_clk);
      start = (poke && c == poke_at && busy);
      if (init_done || init_err) begin got = 1; break; end
    end
    start = 1'b0;
    check({nm, "_finished"}, {63'b0, got}, 64'd1);
    check({nm, "_dummy_cycles"}, dummy_cnt, NDUMMY);
    check({nm, "_cmds_left"}, exp_q.size(), 0);
    check({nm, "_status"}, {58'b0, busy, init_done, init_err, err_code}, {58'b0, 1'b0, e_done, e_err, e_code});
    check({nm, "_card"}, {62'b0, card_v2, card_hc}, {62'b0, e_v2, e_hc});
    repeat (4) @(negedge input_clk);
    check({nm, "_sticky"}, {58'b0, busy, init_done, init_err, err_code}, {58'b0, 1'b0, e_done, e_err, e_code});
  endtask

  initial begin
    bit got;
    int base;
    resend = 1'b0; start = 1'b0;
    s_cmd0_fail = 0; s_cmd8 = 0; s_cmd55_bad = 0; s_idle = 0; s_ext58 = '0;
    s_stmax = 0; s_force_stall = 0; s_hold41 = 0;
    repeat (3) @(negedge input_clk);
    check("reset_outputs", outs(), 64'd0);
    resend = 1'b1;
    repeat (2) @(negedge input_clk);
    check("idle_outputs", outs(), 64'd0);

    run("nominal_v2_hc", 0, 0, 0, 0, 32'hC0FF_8000, 5, 1, 0);
    run("v1_card",       0, 1, 0, 1, 32'h0,         2, 0, 0);
    run("cmd0_all_fail", 8, 0, 0, 0, 32'hC0FF_8000, 2, 0, 0);
    run("cmd0_7_fail",   7, 0, 0, 0, 32'hC0FF_8000, 1, 0, 0);
    run("a41_exhaust",   0, 0, 0, 9, 32'hC0FF_8000, 2, 0, 0);
    run("a41_idle3",     0, 0, 0, 3, 32'h8000_0000, 2, 0, 0);
    run("cmd8_bad",      1, 2, 0, 0, 32'hC0FF_8000, 2, 0, 0);
    run("cmd55_bad",     0, 1, 1, 0, 32'hC0FF_8000, 2, 0, 0);
    run("cmd58_nopwr",   0, 0, 0, 1, 32'h40FF_8000, 2, 0, 0);

    // Reset while waiting for the ACMD41 response
    s_cmd0_fail = 0; s_cmd8 = 0; s_cmd55_bad = 0; s_idle = 0; s_ext58 = 32'hC0FF_8000;
    s_stmax = 2; s_force_stall = 0; s_hold41 = 1;
    build_expected();
    base = n41_seen;
    pulse_start();
    got = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge input_clk);
      if (n41_seen > base) begin got = 1; break; end
    end
    check("w41_reached", {63'b0, got}, 64'd1);
    check("w41_cmds_left", exp_q.size(), 0);
    repeat (2) @(negedge input_clk);
    resend = 1'b0;
    @(negedge input_clk);
    check("mid_reset_outputs", outs(), 64'd0);
    resend = 1'b1;
    s_hold41 = 0;
    run("after_reset", 0, 0, 0, 0, 32'hC0FF_8000, 3, 0, 1);

    for (int i = 0; i < 6; i++) begin
      int r;
      r = $urandom_range(0, 9);
      run("random", r > 7 ? 8 : r % 3, $urandom_range(0, 2), $urandom_range(0, 5) == 0,
          $urandom_range(0, 5), $urandom, $urandom_range(0, 4), 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
